fractal_render: RTL

- Parametrised successor to the fixed-view fractal core.
- Scans an H_RES x V_RES frame and iterates z <- z^2 + c in signed fixed point for each pixel.
- Writes each pixel's escape count to the pixel_gen framebuffer port (addr_w/din/wea), then raises display to release vga_sync.
- New over the previous core: view window (start/step) latched at runtime on a start handshake, selectable Mandelbrot/Julia mode, configurable resolution, precision and iteration limit.

---
 rtl/fractal_pkg.sv | 26 ++
 rtl/fractal_render_if.sv | 31 +++
 rtl/fractal_iter_step.sv | 35 +++
 rtl/fractal_render.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared types and fixed-point helpers for the fractal render engine.
package fractal_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ITER  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // |z|^2 threshold (4.0) expressed at the 2*FRAC scale of a full product
    function automatic logic [63:0] escape_limit(input int unsigned frac);
        return 64'd4 << (2 * frac);
    endfunction

    // Full-precision signed product rescaled back to the operand scale
    function automatic logic signed [63:0] fx_mul_shift(input logic signed [31:0] a,
                                                        input logic signed [31:0] b,
                                                        input int unsigned frac);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p >>> frac;
    endfunction

endpackage

// File: rtl/fractal_render_if.sv
// Control/view and framebuffer signals between a frame requester and the render engine.
interface fractal_render_if #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 7,
    parameter int ADDR_W = 19
);
    logic                     start;
    logic                     julia_mode;
    logic signed [WIDTH-1:0]  startX;
    logic signed [WIDTH-1:0]  startY;
    logic signed [WIDTH-1:0]  stepX;
    logic signed [WIDTH-1:0]  stepY;
    logic signed [WIDTH-1:0]  juliaCr;
    logic signed [WIDTH-1:0]  juliaCi;
    logic [ADDR_W-1:0]        addr_w;
    logic [ITER_W-1:0]        din;
    logic                     wea;
    logic                     busy;
    logic                     frame_done;
    logic                     display;

    modport master (
        output start, julia_mode, startX, startY, stepX, stepY, juliaCr, juliaCi,
        input  addr_w, din, wea, busy, frame_done, display
    );

    modport slave (
        input  start, julia_mode, startX, startY, stepX, stepY, juliaCr, juliaCi,
        output addr_w, din, wea, busy, frame_done, display
    );
endinterface

// File: rtl/fractal_iter_step.sv
// One combinational z <- z^2 + c step with escape test on the incoming z.
module fractal_iter_step
    import fractal_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic signed [WIDTH-1:0] zr,
    input  logic signed [WIDTH-1:0] zi,
    input  logic signed [WIDTH-1:0] cr,
    input  logic signed [WIDTH-1:0] ci,
    output logic signed [WIDTH-1:0] zr_next,
    output logic signed [WIDTH-1:0] zi_next,
    output logic                    escaped
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW:0] ESCAPE_LIMIT = (PW+1)'(escape_limit(FRAC));

    logic signed [PW-1:0] sq_r;
    logic signed [PW-1:0] sq_i;
    logic signed [PW:0]   mag;
    logic signed [PW:0]   diff;

    // Sum and difference carry one guard bit so the compare never wraps
    always_comb begin
        sq_r    = PW'(zr) * PW'(zr);
        sq_i    = PW'(zi) * PW'(zi);
        mag     = (PW+1)'(sq_r) + (PW+1)'(sq_i);
        diff    = (PW+1)'(sq_r) - (PW+1)'(sq_i);
        escaped = mag > ESCAPE_LIMIT;
        zr_next = WIDTH'(diff >>> FRAC) + cr;
        zi_next = WIDTH'(fx_mul_shift(32'(zr) <<< 1, 32'(zi), FRAC)) + ci;
    end

endmodule

// File: rtl/fractal_render.sv
// Frame scanner: iterates every pixel of the view window and writes escape counts.
//   state | meaning
//   IDLE  | wait for start, latch view window
//   INIT  | seed z/c for the pixel and evaluate step 0
//   ITER  | one iteration per cycle until escape or cap
//   WRITE | framebuffer strobe, advance pixel position
//   DONE  | frame_done pulse, raise display
module fractal_render
    import fractal_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 12,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int ITER_W   = 7,
    parameter int MAX_ITER = 127,
    parameter int ADDR_W   = 19
) (
    input  logic         Clk_100M,
    input  logic         reset,
    fractal_render_if.slave bus
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    state_t state, state_next;

    logic                    julia_q;
    logic signed [WIDTH-1:0] start_x_q, step_x_q, step_y_q, julia_cr_q, julia_ci_q;
    logic signed [WIDTH-1:0] px, py, zr, zi, cr_q, ci_q;
    logic signed [WIDTH-1:0] s_zr, s_zi, s_cr, s_ci, zr_next, zi_next;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic [ITER_W-1:0]       k, k_eval;
    logic [ADDR_W-1:0]       addr_cnt;
    logic                    escaped, iter_done, last_x, last_pixel;

    // INIT feeds the seed straight into the step so k=0 costs no extra cycle
    always_comb begin
        s_zr   = zr;
        s_zi   = zi;
        s_cr   = cr_q;
        s_ci   = ci_q;
        k_eval = k;
        if (state == S_INIT) begin
            k_eval = '0;
            if (julia_q) begin
                s_zr = px;
                s_zi = py;
                s_cr = julia_cr_q;
                s_ci = julia_ci_q;
            end else begin
                s_zr = '0;
                s_zi = '0;
                s_cr = px;
                s_ci = py;
            end
        end
    end

    fractal_iter_step #(.WIDTH(WIDTH), .FRAC(FRAC)) u_step (
        .zr      (s_zr),
        .zi      (s_zi),
        .cr      (s_cr),
        .ci      (s_ci),
        .zr_next (zr_next),
        .zi_next (zi_next),
        .escaped (escaped)
    );

    assign iter_done  = escaped || (k_eval == ITER_W'(MAX_ITER));
    assign last_x     = (x == XW'(H_RES - 1));
    assign last_pixel = last_x && (y == YW'(V_RES - 1));

    always_ff @(posedge Clk_100M) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:         if (bus.start) state_next = S_INIT;
            S_INIT, S_ITER: state_next = iter_done ? S_WRITE : S_ITER;
            S_WRITE:        state_next = last_pixel ? S_DONE : S_INIT;
            S_DONE:         state_next = S_IDLE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.wea        = (state == S_WRITE);
        bus.frame_done = (state == S_DONE);
    end

    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            julia_q     <= 1'b0;
            start_x_q   <= '0;
            step_x_q    <= '0;
            step_y_q    <= '0;
            julia_cr_q  <= '0;
            julia_ci_q  <= '0;
            px          <= '0;
            py          <= '0;
            zr          <= '0;
            zi          <= '0;
            cr_q        <= '0;
            ci_q        <= '0;
            x           <= '0;
            y           <= '0;
            k           <= '0;
            addr_cnt    <= '0;
            bus.addr_w  <= '0;
            bus.din     <= '0;
            bus.busy    <= 1'b0;
            bus.display <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        julia_q    <= bus.julia_mode;
                        start_x_q  <= bus.startX;
                        step_x_q   <= bus.stepX;
                        step_y_q   <= bus.stepY;
                        julia_cr_q <= bus.juliaCr;
                        julia_ci_q <= bus.juliaCi;
                        px         <= bus.startX;
                        py         <= bus.startY;
                        x          <= '0;
                        y          <= '0;
                        addr_cnt   <= '0;
                        bus.busy   <= 1'b1;
                    end
                end
                S_INIT, S_ITER: begin
                    cr_q <= s_cr;
                    ci_q <= s_ci;
                    if (iter_done) begin
                        bus.din    <= k_eval;
                        bus.addr_w <= addr_cnt;
                    end else begin
                        zr <= zr_next;
                        zi <= zi_next;
                        k  <= k_eval + ITER_W'(1);
                    end
                end
                S_WRITE: begin
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                    if (last_x) begin
                        x  <= '0;
                        px <= start_x_q;
                        y  <= y + YW'(1);
                        py <= py + step_y_q;
                    end else begin
                        x  <= x + XW'(1);
                        px <= px + step_x_q;
                    end
                end
                S_DONE: begin
                    bus.busy    <= 1'b0;
                    bus.display <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
